// File: rtl/phase_sequencer.sv
// Timed phase sequencer: steps NUM_PHASES phases, each lasting a loaded number of seconds.
// Optional SEQ_PAUSE_EN adds a pause input that freezes counting while in RUN.
module phase_sequencer #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int NUM_PHASES    = 4,
    parameter int SEC_W         = 16,
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
`ifdef SEQ_PAUSE_EN
    input  logic                        pause,
`endif
    input  logic [NUM_PHASES*SEC_W-1:0] durations,
    output logic [PH_W-1:0]             phase,
    output logic                        busy,
    output logic [SEC_W-1:0]            sec_remaining,
    output logic                        phase_done,
    output logic                        seq_done
);

    // IDLE wait for start | LOAD fetch duration | RUN count seconds | DONE seq_done cycle
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);
    localparam logic [PS_W-1:0] PS_MAX  = PS_W'(TICKS_PER_SEC - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [PS_W-1:0]   pre_q, pre_d;
    logic              busy_q, busy_d;
    logic              pdone_q, pdone_d;
    logic              sdone_q, sdone_d;
    logic [SEC_W-1:0]  dur_sel;
    logic              run_hold;

`ifdef SEQ_PAUSE_EN
    assign run_hold = pause;
`else
    assign run_hold = 1'b0;
`endif

    assign dur_sel = durations[phase_q*SEC_W +: SEC_W];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sec_d   = sec_q;
        pre_d   = pre_q;
        pdone_d = 1'b0;
        sdone_d = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    phase_d = '0;
                end
            end
            S_LOAD: begin
                pre_d = '0;
                sec_d = dur_sel;
                if (dur_sel != '0) begin
                    state_d = S_RUN;
                end else begin
                    // zero-length phase: finish it immediately, same as an expiry
                    pdone_d = 1'b1;
                    if (phase_q == LAST_PH) begin
                        state_d = S_DONE;
                        sdone_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (!run_hold) begin
                    if (pre_q == PS_MAX) begin
                        pre_d = '0;
                        if (sec_q <= SEC_W'(1)) begin
                            sec_d   = '0;
                            pdone_d = 1'b1;
                            if (phase_q == LAST_PH) begin
                                state_d = S_DONE;
                                sdone_d = 1'b1;
                            end else begin
                                state_d = S_LOAD;
                                phase_d = phase_q + PH_W'(1);
                            end
                        end else begin
                            sec_d = sec_q - SEC_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PS_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort wins over everything except reset and drops any pending pulse
        if (abort) begin
            state_d = S_IDLE;
            phase_d = '0;
            sec_d   = '0;
            pre_d   = '0;
            pdone_d = 1'b0;
            sdone_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            sec_q   <= '0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            pdone_q <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sec_q   <= sec_d;
            pre_q   <= pre_d;
            busy_q  <= busy_d;
            pdone_q <= pdone_d;
            sdone_q <= sdone_d;
        end
    end

    assign phase         = phase_q;
    assign busy          = busy_q;
    assign sec_remaining = sec_q;
    assign phase_done    = pdone_q;
    assign seq_done      = sdone_q;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Controller that steps a fixed set of timed phases (e.g. clock/alarm/display modes) off the 10 kHz system clock.
- Contains the seconds prescaler and a per-phase down-counter.
- Loads each phase's duration in seconds, runs it to expiry, then advances.
- Reports the current phase, the remaining seconds and completion pulses to the display/control logic.

Parameters:
- TICKS_PER_SEC, 10000: CLK cycles per second; the bench uses 10.
- NUM_PHASES, 4: number of phases in the sequence, 2..16.
- SEC_W, 16: width of each duration and of the remaining-seconds counter.

Ports:
- CLK  in  1  system clock, 10 kHz nominal.
- reset  in  1  synchronous, active-high; all state clears on the CLK edge where reset=1.
- start  in  1  level-sampled; starts the sequence from phase 0 when idle.
- abort  in  1  level-sampled; returns to IDLE from any state.
- durations  in  NUM_PHASES*SEC_W  packed durations in seconds; phase k occupies bits [k*SEC_W +: SEC_W].
- phase  out  clog2(NUM_PHASES)  index of the current phase.
- busy  out  1  high in LOAD, RUN and DONE.
- sec_remaining  out  SEC_W  whole seconds left in the current phase.
- phase_done  out  1  one-cycle pulse when a phase ends.
- seq_done  out  1  one-cycle pulse after the last phase ends.

Behaviour:
- Reset values: state=IDLE, phase=0, busy=0, sec_remaining=0, phase_done=0, seq_done=0, prescaler=0.
- All outputs are registered.
- IDLE:
  - start=1 and abort=0 -> LOAD, phase=0.
  - start while busy is ignored.
- LOAD (exactly 1 cycle):
  - sec_remaining <= durations[phase]; prescaler <= 0.
  - Duration nonzero -> RUN.
  - Duration zero -> the phase is skipped: phase_done pulses in the next cycle, then advance as at expiry.
  - Durations are sampled only in LOAD; changing them mid-phase has no effect until the next LOAD.
- RUN:
  - prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - On each wrap cycle (prescaler==TICKS_PER_SEC-1), sec_remaining decrements.
  - Wrap cycle with sec_remaining==1: sec_remaining becomes 0 and phase_done=1 in the following cycle.
  - After that wrap: phase<NUM_PHASES-1 -> phase+1 and LOAD; otherwise -> DONE.
- Phase length: a phase of N seconds spends exactly N*TICKS_PER_SEC cycles in RUN, plus 1 LOAD cycle.
- DONE (1 cycle): seq_done=1, then IDLE with phase held at NUM_PHASES-1 and busy=0.
- Latency:
  - start sampled at edge t -> busy=1, state LOAD at t+1 -> RUN at t+2.
  - sec_remaining is valid from t+2.
- abort:
  - Any state -> IDLE on the next edge.
  - sec_remaining=0, phase=0, prescaler=0.
  - No phase_done or seq_done pulse; a pending pulse is suppressed.
- Priority: reset > abort > start. start and abort high together -> abort wins, block stays IDLE.
- reset mid-RUN: all counters clear on that edge; no pulses.
- The prescaler never exceeds TICKS_PER_SEC-1; sec_remaining never underflows below 0.

Optional Feature:
- SEQ_PAUSE_EN defined:
  - Adds input port pause (1 bit), placed after abort.
  - While pause=1 in RUN, prescaler and sec_remaining hold and no pulses occur.
  - Counting resumes from the held prescaler value when pause drops.
  - pause has no effect in IDLE, LOAD or DONE; abort overrides pause.
- SEQ_PAUSE_EN undefined: no pause port; RUN always counts.

Test Plan (TICKS_PER_SEC=10, NUM_PHASES=4, SEC_W=16):
- Reset, then durations={3,2,1,2}, start pulse at t=0 -> phase steps 0,1,2,3.
  - Phases last 31, 21, 11 and 21 cycles including LOAD.
  - phase_done pulses 4 times; seq_done pulses once; busy=0 afterwards.
- Durations={2,0,0,1}, start -> phases 1 and 2 each take 1 LOAD cycle plus a phase_done pulse, no RUN cycles; total busy window 2+1+1+... matches the cycle count; seq_done asserted once.
- abort at sec_remaining=1 in phase 2 -> next cycle IDLE, phase=0, sec_remaining=0; no phase_done or seq_done.
- start and abort both high while IDLE -> remains IDLE, busy=0; start re-asserted during RUN -> no restart, phase timing unchanged.
- Change durations[1] from 2 to 5 while phase 0 runs -> phase 1 lasts 5 s (50 cycles); change it again during phase 1 -> no effect.
- SEQ_PAUSE_EN: pause high for 37 cycles mid phase 0 (duration 3) -> phase_done is delayed by exactly 37 cycles and sec_remaining is frozen during the pause; without the macro the port is absent.
